adc_avg_seq: RTL and testbench
==============================

ADC_AVG_SEQ -- requirements
Module: adc_avg_seq

Interface
REQ-001 Parameter LOG2_N, default 4: block size N = 2^LOG2_N samples per average, legal range 1..8.
REQ-002 Parameter PERIOD, default 2400: clk_i cycles from one start_o pulse to the next within a block, minimum 4.
REQ-003 Parameter TIMEOUT, default 4096: maximum clk_i cycles in WAIT before abort, minimum 2.
REQ-004 clk_i  input  1  single 100 MHz system clock; all logic on rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 en_i  input  1  level enable; high runs blocks back to back.
REQ-007 start_o  output  1  one-cycle conversion request; drives the SPI reader's button input.
REQ-008 eoc_i  input  1  end-of-conversion from the SPI reader; only rising edges are used.
REQ-009 din_i  input  12  sample from the SPI reader; sampled in the cycle the eoc_i rising edge is detected.
REQ-010 avg_o  output  12  last block average; held until the next block completes.
REQ-011 avg_valid_o  output  1  one-cycle pulse when avg_o updates.
REQ-012 busy_o  output  1  high in any state except IDLE.
REQ-013 err_o  output  1  one-cycle pulse on a WAIT timeout.

Function
REQ-014 FSM states: IDLE, TRIG, WAIT, GAP, DONE.
REQ-015 IDLE: en_i=1 moves to TRIG next cycle; otherwise stays in IDLE.
REQ-016 TRIG: start_o=1 for exactly this cycle; load period timer with PERIOD and timeout timer with TIMEOUT; go to WAIT.
REQ-017 WAIT, eoc_i rising edge: acc <= acc + din_i; cnt <= cnt + 1; if cnt = N-1, go to DONE, else go to GAP.
REQ-018 WAIT, timeout timer expires with no edge: err_o=1; acc and cnt cleared; go to IDLE.
REQ-019 Edge detect registers eoc_i once; edge = eoc_i & ~eoc_q; edges outside WAIT are ignored.
REQ-020 GAP: when the period timer expires, go to TRIG if en_i=1; go to IDLE, clearing acc and cnt, if en_i=0.
REQ-021 DONE: avg_o <= (acc + final sample) >> LOG2_N, truncated with no rounding; avg_valid_o=1 this cycle; acc and cnt cleared; go to IDLE.
REQ-022 Width of acc is 12+LOG2_N bits and shall never overflow; cnt is LOG2_N bits wide.
REQ-023 In WAIT, en_i=0 has no effect; the conversion completes or times out first.
REQ-024 Eoc edge and timer expiry in the same cycle: the edge wins and no err_o is raised.
REQ-025 Latency from the final eoc_i edge to avg_valid_o is 2 cycles: edge detect, then DONE.
REQ-026 Back-to-back operation: spacing between consecutive start_o pulses within a block is exactly PERIOD cycles.

Reset
REQ-027 While rst_ni=0: state=IDLE; start_o, avg_valid_o, err_o, busy_o = 0; avg_o = 12'h000; acc, cnt, timers and eoc_q = 0.
REQ-028 Reset asserted mid-block discards the partial sum; after release no start_o occurs before en_i is sampled high in IDLE.

Structure
REQ-029 Package adc_avg_pkg holds the state encoding (localparams), the 12-bit sample width constant and the default PERIOD/TIMEOUT values.
REQ-030 One sub-module, cycle_timer (load, count down, expire pulse), shall be instantiated twice: once as the period timer and once as the timeout timer.

Verification
Bench parameters: LOG2_N=2, PERIOD=8, TIMEOUT=64; eoc_i is driven as a one-cycle pulse.
REQ-031 Reset held for 3 cycles -> all outputs 0, busy_o=0, no start_o pulse.
REQ-032 en_i=1 with samples 100, 200, 300, 400 -> four start_o pulses 8 cycles apart; avg_o=250 with one-cycle avg_valid_o 2 cycles after the 4th eoc.
REQ-033 Four samples of 12'hFFF -> avg_o=12'hFFF (no overflow); samples 1, 1, 1, 2 -> avg_o=1 (truncation).
REQ-034 No eoc_i after start_o -> err_o pulse 64 cycles after start_o, no avg_valid_o; the next block with 4 samples of 8 gives avg_o=8 (no stale sum).
REQ-035 en_i dropped after 2 samples (during GAP) -> return to IDLE, busy_o=0, no avg_valid_o; avg_o keeps its previous value.
REQ-036 rst_ni pulsed low during WAIT -> outputs reset at once; an eoc_i edge during reset is ignored.

Source files
------------

// File: rtl/adc_avg_pkg.sv
// Shared constants and state encoding for the ADC block averager.
// Contents: sample width, default period/timeout, FSM state encoding and enum type.
package adc_avg_pkg;

  localparam int unsigned SampleW    = 12;
  localparam int unsigned DefPeriod  = 2400;
  localparam int unsigned DefTimeout = 4096;

  localparam logic [2:0] StIdleEnc = 3'd0;
  localparam logic [2:0] StTrigEnc = 3'd1;
  localparam logic [2:0] StWaitEnc = 3'd2;
  localparam logic [2:0] StGapEnc  = 3'd3;
  localparam logic [2:0] StDoneEnc = 3'd4;

  typedef enum logic [2:0] {
    StIdle = StIdleEnc,
    StTrig = StTrigEnc,
    StWait = StWaitEnc,
    StGap  = StGapEnc,
    StDone = StDoneEnc
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   i_load         load i_value this cycle (takes priority over counting)
//   i_value        count loaded on i_load
//   o_expire       high while the count equals 1 (last cycle before reaching zero)
//   o_zero         high while the count is zero (timer idle / already expired)
module cycle_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_expire,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == WIDTH'(1));
  assign o_zero   = (r_cnt == '0);

endmodule

// File: rtl/adc_avg_seq.sv
// Sequences ADC conversions and averages blocks of 2^LOG2_N samples.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           level enable; blocks run back to back while high
//   start_o        one-cycle conversion request
//   eoc_i, din_i   end-of-conversion (rising edge used) and sample
//   avg_o          last block average, held until the next block completes
//   avg_valid_o    one-cycle pulse when avg_o updates
//   busy_o         high outside IDLE
//   err_o          one-cycle pulse when a conversion times out
module adc_avg_seq
  import adc_avg_pkg::*;
#(
  parameter int unsigned LOG2_N  = 4,
  parameter int unsigned PERIOD  = DefPeriod,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  output logic               start_o,
  input  logic               eoc_i,
  input  logic [SampleW-1:0] din_i,
  output logic [SampleW-1:0] avg_o,
  output logic               avg_valid_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned AccW = SampleW + LOG2_N;
  localparam int unsigned PerW = $clog2(PERIOD + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [LOG2_N-1:0] CntLast = '1;

  state_e              r_state;
  logic [AccW-1:0]     r_acc;
  logic [LOG2_N-1:0]   r_cnt;
  logic                r_eoc_q;
  logic                r_start;
  logic                r_avg_valid;
  logic                r_err;
  logic [SampleW-1:0]  r_avg;

  logic w_edge;
  logic w_tmr_load;
  logic w_per_exp, w_per_zero;
  logic w_tmo_exp, w_tmo_zero;

  assign w_edge     = eoc_i & ~r_eoc_q;
  assign w_tmr_load = (r_state == StTrig);

  // Both timers load value-1 so expiry is seen in the cycle before the next
  // state, giving exactly PERIOD / TIMEOUT cycles from start_o.
  cycle_timer #(
    .WIDTH (PerW)
  ) u_period_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_load   (w_tmr_load),
    .i_value  (PerW'(PERIOD - 1)),
    .o_expire (w_per_exp),
    .o_zero   (w_per_zero)
  );

  cycle_timer #(
    .WIDTH (TmoW)
  ) u_timeout_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_load   (w_tmr_load),
    .i_value  (TmoW'(TIMEOUT - 1)),
    .o_expire (w_tmo_exp),
    .o_zero   (w_tmo_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_eoc_q     <= 1'b0;
      r_start     <= 1'b0;
      r_avg_valid <= 1'b0;
      r_err       <= 1'b0;
      r_avg       <= '0;
    end else begin
      r_eoc_q     <= eoc_i;
      r_start     <= 1'b0;
      r_avg_valid <= 1'b0;
      r_err       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (en_i) begin
            r_state <= StTrig;
            r_start <= 1'b1;
          end
        end
        StTrig: r_state <= StWait;
        StWait: begin
          // An edge coinciding with timeout expiry wins.
          if (w_edge) begin
            r_acc   <= r_acc + AccW'(din_i);
            r_cnt   <= r_cnt + 1'b1;
            r_state <= (r_cnt == CntLast) ? StDone : StGap;
          end else if (w_tmo_exp || w_tmo_zero) begin
            r_err   <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= StIdle;
          end
        end
        StGap: begin
          // Zero covers a period that already ran out during a slow conversion.
          if (w_per_exp || w_per_zero) begin
            if (en_i) begin
              r_state <= StTrig;
              r_start <= 1'b1;
            end else begin
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= StIdle;
            end
          end
        end
        StDone: begin
          // Accumulator already holds the final sample.
          r_avg       <= r_acc[AccW-1:LOG2_N];
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign start_o     = r_start;
  assign avg_o       = r_avg;
  assign avg_valid_o = r_avg_valid;
  assign err_o       = r_err;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_adc_avg_seq.sv
// Directed self-checking bench for adc_avg_seq (LOG2_N=2, PERIOD=8, TIMEOUT=64).
module tb_adc_avg_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        eoc;
  logic [11:0] din;
  logic [11:0] avg;
  logic        avg_valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  adc_avg_seq #(
    .LOG2_N  (2),
    .PERIOD  (8),
    .TIMEOUT (64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .start_o     (start),
    .eoc_i       (eoc),
    .din_i       (din),
    .avg_o       (avg),
    .avg_valid_o (avg_valid),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(output int t);
    int n;
    n = 0;
    while (start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("start_seen", {31'd0, start}, 1);
    t = cyc;
  endtask

  // One cycle into WAIT, then a one-cycle eoc pulse carrying v.
  task automatic send_sample(input logic [11:0] v);
    step();
    chk("start_one_cycle", {31'd0, start}, 0);
    eoc = 1'b1;
    din = v;
    step();
    eoc = 1'b0;
  endtask

  task automatic run_block(input logic [11:0] s0, s1, s2, s3, input int exp_avg,
                           input string tag);
    logic [11:0] s [4];
    int t, tp;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    tp = 0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(t);
      if (k > 0) chk({tag, "_period"}, t - tp, 8);
      tp = t;
      chk({tag, "_busy"}, {31'd0, busy}, 1);
      send_sample(s[k]);
    end
    chk({tag, "_valid_early"}, {31'd0, avg_valid}, 0);
    step();
    chk({tag, "_valid"}, {31'd0, avg_valid}, 1);
    chk({tag, "_avg"}, {20'd0, avg}, exp_avg);
    en = 1'b0;
    step();
    chk({tag, "_valid_pulse"}, {31'd0, avg_valid}, 0);
  endtask

  initial begin
    int t, n, va, st;
    rst_n = 1'b0;
    en    = 1'b0;
    eoc   = 1'b0;
    din   = '0;

    // Reset held for 3 cycles.
    repeat (3) begin
      step();
      chk("rst_start", {31'd0, start}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_valid", {31'd0, avg_valid}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_avg", {20'd0, avg}, 0);
    end
    rst_n = 1'b1;
    step();
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_start", {31'd0, start}, 0);

    run_block(12'd100, 12'd200, 12'd300, 12'd400, 250, "avg250");
    run_block(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, "max");
    run_block(12'd1, 12'd1, 12'd1, 12'd2, 1, "trunc");

    // Timeout: no eoc after start.
    en = 1'b1;
    wait_start(t);
    en = 1'b0;
    n = 0;
    va = 0;
    while (err !== 1'b1 && n < 100) begin
      step();
      n++;
      if (avg_valid === 1'b1) va++;
    end
    chk("err_seen", {31'd0, err}, 1);
    chk("err_latency", cyc - t, 64);
    chk("err_no_valid", va, 0);
    chk("err_busy", {31'd0, busy}, 0);
    chk("err_avg_held", {20'd0, avg}, 1);
    step();
    chk("err_pulse", {31'd0, err}, 0);
    run_block(12'd8, 12'd8, 12'd8, 12'd8, 8, "after_to");

    // en dropped during GAP after two samples.
    en = 1'b1;
    wait_start(t);
    send_sample(12'd50);
    wait_start(t);
    send_sample(12'd60);
    en = 1'b0;
    va = 0;
    st = 0;
    repeat (12) begin
      step();
      if (avg_valid === 1'b1) va++;
      if (start === 1'b1) st++;
    end
    chk("drop_no_valid", va, 0);
    chk("drop_no_start", st, 0);
    chk("drop_busy", {31'd0, busy}, 0);
    chk("drop_avg_held", {20'd0, avg}, 8);
    run_block(12'd4, 12'd4, 12'd4, 12'd4, 4, "after_drop");

    // Reset pulsed during WAIT, with an eoc edge while in reset.
    en = 1'b1;
    wait_start(t);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_start", {31'd0, start}, 0);
    chk("midrst_avg", {20'd0, avg}, 0);
    en  = 1'b0;
    eoc = 1'b1;
    din = 12'd999;
    step();
    eoc = 1'b0;
    step();
    rst_n = 1'b1;
    st = 0;
    repeat (5) begin
      step();
      if (start === 1'b1) st++;
    end
    chk("postrst_no_start", st, 0);
    chk("postrst_busy", {31'd0, busy}, 0);
    chk("postrst_valid", {31'd0, avg_valid}, 0);
    run_block(12'd20, 12'd20, 12'd20, 12'd24, 21, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
